// File: rtl/regfile_np_if.sv
`timescale 1ns/1ps
// Bus bundle between the decode/control FSM (master) and regfile_np (slave).
interface regfile_np_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              rd_pend_a;
  logic              rd_pend_b;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           pend_set, pend_addr, clr_req,
    input  rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, clr_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           pend_set, pend_addr, clr_req,
    output rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, clr_busy
  );
endinterface

// File: rtl/regfile_np.sv
`timescale 1ns/1ps
// Two-read register file with write bypass, optional hardwired-zero entry,
// per-entry pending scoreboard and a sweep-clear sequencer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | normal operation; writes, pending sets and bypass active
// ST_SWEEP | clearing entry ptr_q each cycle; writes/sets dropped
module regfile_np #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input logic       clk,
  input logic       rst,
  regfile_np_if.slave bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic              HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic busy;
  logic wr_ok;
  logic set_ok;
  logic zero_a, zero_b;
  logic hit_wr_a, hit_wr_b;
  logic hit_set_a, hit_set_b;

  // Entry 0 is treated as a constant when the zero register is enabled, so
  // writes and sets aimed at it are discarded before they reach storage.
  assign busy   = (state_q == ST_SWEEP);
  assign wr_ok  = bus.wr_en & ~busy & ~(HAS_ZERO & (bus.wr_addr == '0));
  assign set_ok = bus.pend_set & ~busy & ~(HAS_ZERO & (bus.pend_addr == '0));

  assign zero_a    = HAS_ZERO & (bus.rd_addr_a == '0);
  assign zero_b    = HAS_ZERO & (bus.rd_addr_b == '0);
  assign hit_wr_a  = wr_ok & (bus.wr_addr == bus.rd_addr_a);
  assign hit_wr_b  = wr_ok & (bus.wr_addr == bus.rd_addr_b);
  assign hit_set_a = set_ok & (bus.pend_addr == bus.rd_addr_a);
  assign hit_set_b = set_ok & (bus.pend_addr == bus.rd_addr_b);

  assign bus.clr_busy = busy;

  // Sweep state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep next state: one entry per cycle, leave after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage and scoreboard update; a same-cycle pending set overrides the
  // clear implied by a write to the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      pend_q <= '0;
    end else if (busy) begin
      data_q[ptr_q] <= '0;
      pend_q[ptr_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        data_q[bus.wr_addr] <= bus.wr_data;
        pend_q[bus.wr_addr] <= 1'b0;
      end
      if (set_ok) begin
        pend_q[bus.pend_addr] <= 1'b1;
      end
    end
  end

  // Read data with write-through bypass; no bypass while sweeping.
  always_comb begin
    bus.rd_data_a = data_q[bus.rd_addr_a];
    if (hit_wr_a) bus.rd_data_a = bus.wr_data;
    if (zero_a)   bus.rd_data_a = '0;

    bus.rd_data_b = data_q[bus.rd_addr_b];
    if (hit_wr_b) bus.rd_data_b = bus.wr_data;
    if (zero_b)   bus.rd_data_b = '0;
  end

  // Pending flags report the value the entry will hold after this edge.
  always_comb begin
    bus.rd_pend_a = pend_q[bus.rd_addr_a];
    if (hit_wr_a)  bus.rd_pend_a = 1'b0;
    if (hit_set_a) bus.rd_pend_a = 1'b1;
    if (zero_a)    bus.rd_pend_a = 1'b0;

    bus.rd_pend_b = pend_q[bus.rd_addr_b];
    if (hit_wr_b)  bus.rd_pend_b = 1'b0;
    if (hit_set_b) bus.rd_pend_b = 1'b1;
    if (zero_b)    bus.rd_pend_b = 1'b0;
  end
endmodule

// File: tb/tb_regfile_np.sv
`timescale 1ns/1ps
// Bench for regfile_np: one instance without and one with the zero register,
// driven by the same stimulus and compared against a reference model.
module tb_regfile_np;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       s_rst, s_wr_en, s_pend_set, s_clr_req;
  logic [2:0] s_wr_addr, s_pend_addr, s_ra, s_rb;
  logic [7:0] s_wr_data;

  regfile_np_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regfile_np_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  assign bus0.wr_en = s_wr_en;     assign bus1.wr_en = s_wr_en;
  assign bus0.wr_addr = s_wr_addr; assign bus1.wr_addr = s_wr_addr;
  assign bus0.wr_data = s_wr_data; assign bus1.wr_data = s_wr_data;
  assign bus0.rd_addr_a = s_ra;    assign bus1.rd_addr_a = s_ra;
  assign bus0.rd_addr_b = s_rb;    assign bus1.rd_addr_b = s_rb;
  assign bus0.pend_set = s_pend_set;   assign bus1.pend_set = s_pend_set;
  assign bus0.pend_addr = s_pend_addr; assign bus1.pend_addr = s_pend_addr;
  assign bus0.clr_req = s_clr_req; assign bus1.clr_req = s_clr_req;

  regfile_np #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(s_rst), .bus(bus0)
  );
  regfile_np #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(s_rst), .bus(bus1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: contents per instance plus the number of sweep cycles left.
  logic [7:0] m_data [2][DEPTH];
  bit         m_pend [2][DEPTH];
  int         sw_left = 0;
  int         sw_idx  = 0;

  function automatic bit is_zero(input int z, input logic [2:0] a);
    return (z == 1) && (a == 3'd0);
  endfunction

  function automatic logic [7:0] exp_rd(input int z, input logic [2:0] a);
    if (is_zero(z, a)) return 8'h00;
    if (sw_left == 0 && s_wr_en && s_wr_addr == a) return s_wr_data;
    return m_data[z][a];
  endfunction

  function automatic logic exp_pend(input int z, input logic [2:0] a);
    bit p;
    if (is_zero(z, a)) return 1'b0;
    p = m_pend[z][a];
    if (sw_left == 0) begin
      if (s_wr_en && s_wr_addr == a) p = 1'b0;
      if (s_pend_set && s_pend_addr == a) p = 1'b1;
    end
    return p;
  endfunction

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (s_rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_data[z][i] = 8'h00;
          m_pend[z][i] = 1'b0;
        end
      end else if (sw_left > 0) begin
        m_data[z][sw_idx] = 8'h00;
        m_pend[z][sw_idx] = 1'b0;
      end else begin
        if (s_wr_en && !is_zero(z, s_wr_addr)) begin
          m_data[z][s_wr_addr] = s_wr_data;
          m_pend[z][s_wr_addr] = 1'b0;
        end
        if (s_pend_set && !is_zero(z, s_pend_addr)) m_pend[z][s_pend_addr] = 1'b1;
      end
    end
    if (s_rst) begin
      sw_left = 0;
      sw_idx  = 0;
    end else if (sw_left > 0) begin
      sw_left--;
      sw_idx++;
    end else if (s_clr_req) begin
      sw_left = DEPTH;
      sw_idx  = 0;
    end
  endtask

  task automatic check_inst(input int z, input logic [7:0] da, input logic [7:0] db,
                            input logic pa, input logic pb, input logic bz);
    check($sformatf("z%0d rd_data_a[%0d]", z, s_ra), {24'd0, da}, {24'd0, exp_rd(z, s_ra)});
    check($sformatf("z%0d rd_data_b[%0d]", z, s_rb), {24'd0, db}, {24'd0, exp_rd(z, s_rb)});
    check($sformatf("z%0d rd_pend_a[%0d]", z, s_ra), {31'd0, pa}, {31'd0, exp_pend(z, s_ra)});
    check($sformatf("z%0d rd_pend_b[%0d]", z, s_rb), {31'd0, pb}, {31'd0, exp_pend(z, s_rb)});
    check($sformatf("z%0d clr_busy", z), {31'd0, bz}, {31'd0, (sw_left > 0)});
  endtask

  task automatic settle();
    @(negedge clk);
    check_inst(0, bus0.rd_data_a, bus0.rd_data_b, bus0.rd_pend_a, bus0.rd_pend_b, bus0.clr_busy);
    check_inst(1, bus1.rd_data_a, bus1.rd_data_b, bus1.rd_pend_a, bus1.rd_pend_b, bus1.clr_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic quiet();
    s_rst = 0; s_wr_en = 0; s_pend_set = 0; s_clr_req = 0;
    s_wr_addr = 0; s_wr_data = 0; s_pend_addr = 0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    quiet();
    s_wr_en = 1; s_wr_addr = a; s_wr_data = d;
    step();
    s_wr_en = 0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) write(3'(i), 8'h80 + 8'(i));
  endtask

  // Counts busy cycles after a clr_req edge, with a few writes/sets and a
  // repeated clr_req thrown in while sweeping; bounded at 20 cycles.
  task automatic run_sweep(input string tag);
    int cnt;
    quiet();
    s_clr_req = 1;
    step();
    s_clr_req = 0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      quiet();
      if (c == 2) begin s_wr_en = 1; s_wr_addr = 3'd7; s_wr_data = 8'h55; end
      if (c == 5) begin s_wr_en = 1; s_wr_addr = 3'd0; s_wr_data = 8'h66; end
      if (c == 4) begin s_pend_set = 1; s_pend_addr = 3'd1; end
      if (c == 3) s_clr_req = 1;
      settle();
      if (!bus0.clr_busy) break;
      cnt++;
      tick();
    end
    quiet();
    tick();
    check({tag, " busy cycles"}, cnt, DEPTH);
  endtask

  task automatic check_all_clear(input string tag);
    quiet();
    for (int i = 0; i < DEPTH; i++) begin
      s_ra = 3'(i); s_rb = 3'(DEPTH - 1 - i);
      settle();
      check($sformatf("%s data0[%0d]", tag, i), {24'd0, bus0.rd_data_a}, 32'h0);
      check($sformatf("%s pend0[%0d]", tag, i), {31'd0, bus0.rd_pend_a}, 32'h0);
      check($sformatf("%s data1[%0d]", tag, i), {24'd0, bus1.rd_data_b}, 32'h0);
      tick();
    end
  endtask

  initial begin
    quiet();
    s_ra = 0; s_rb = 0;
    s_rst = 1;
    tick();
    s_rst = 0;
    check_all_clear("reset");

    // basic writes and dual read
    write(3'd3, 8'hA5);
    write(3'd5, 8'h3C);
    s_ra = 3'd3; s_rb = 3'd5;
    settle();
    check("rd A=3", {24'd0, bus0.rd_data_a}, 32'hA5);
    check("rd B=5", {24'd0, bus0.rd_data_b}, 32'h3C);
    check("pend A=3", {31'd0, bus0.rd_pend_a}, 32'h0);
    check("pend B=5", {31'd0, bus0.rd_pend_b}, 32'h0);
    tick();

    // bypass
    write(3'd2, 8'h11);
    s_ra = 3'd2; s_rb = 3'd2;
    s_wr_en = 1; s_wr_addr = 3'd2; s_wr_data = 8'h7E;
    settle();
    check("bypass A", {24'd0, bus0.rd_data_a}, 32'h7E);
    check("bypass B", {24'd0, bus1.rd_data_b}, 32'h7E);
    tick();
    quiet();
    settle();
    check("stored after bypass", {24'd0, bus0.rd_data_a}, 32'h7E);
    tick();

    // scoreboard
    s_ra = 3'd4; s_rb = 3'd4;
    s_pend_set = 1; s_pend_addr = 3'd4;
    settle();
    check("pend set same cycle", {31'd0, bus0.rd_pend_a}, 32'h1);
    tick();
    quiet();
    settle();
    check("pend held", {31'd0, bus0.rd_pend_b}, 32'h1);
    tick();
    s_wr_en = 1; s_wr_addr = 3'd4; s_wr_data = 8'h09;
    settle();
    check("pend cleared by write", {31'd0, bus0.rd_pend_a}, 32'h0);
    tick();
    quiet();
    s_ra = 3'd6; s_rb = 3'd6;
    s_wr_en = 1; s_wr_addr = 3'd6; s_wr_data = 8'h42;
    s_pend_set = 1; s_pend_addr = 3'd6;
    settle();
    check("set wins pend", {31'd0, bus0.rd_pend_a}, 32'h1);
    tick();
    quiet();
    settle();
    check("set wins data", {24'd0, bus0.rd_data_a}, 32'h42);
    check("set wins pend held", {31'd0, bus0.rd_pend_b}, 32'h1);
    tick();

    // zero register
    s_ra = 3'd0; s_rb = 3'd0;
    s_wr_en = 1; s_wr_addr = 3'd0; s_wr_data = 8'hFF;
    s_pend_set = 1; s_pend_addr = 3'd0;
    settle();
    check("zero data wr cycle", {24'd0, bus1.rd_data_a}, 32'h0);
    check("zero pend wr cycle", {31'd0, bus1.rd_pend_a}, 32'h0);
    check("nonzero entry0 bypass", {24'd0, bus0.rd_data_a}, 32'hFF);
    check("nonzero entry0 pend", {31'd0, bus0.rd_pend_b}, 32'h1);
    tick();
    quiet();
    settle();
    check("zero data after", {24'd0, bus1.rd_data_b}, 32'h0);
    check("nonzero entry0 after", {24'd0, bus0.rd_data_b}, 32'hFF);
    tick();

    // full sweep
    fill_all();
    s_ra = 3'd7; s_rb = 3'd0;
    run_sweep("sweep");
    check_all_clear("post sweep");

    // reset in the middle of a sweep
    fill_all();
    quiet();
    s_clr_req = 1;
    step();
    quiet();
    step();
    step();
    s_rst = 1;
    step();
    s_rst = 0;
    settle();
    check("mid-sweep rst busy0", {31'd0, bus0.clr_busy}, 32'h0);
    check("mid-sweep rst busy1", {31'd0, bus1.clr_busy}, 32'h0);
    tick();
    check_all_clear("mid-sweep rst");
    fill_all();
    run_sweep("resweep");

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      s_rst       = ($urandom_range(99) == 0);
      s_wr_en     = ($urandom_range(2) == 0);
      s_wr_addr   = 3'($urandom_range(7));
      s_wr_data   = 8'($urandom);
      s_pend_set  = ($urandom_range(3) == 0);
      s_pend_addr = 3'($urandom_range(7));
      s_clr_req   = ($urandom_range(39) == 0);
      s_ra        = 3'($urandom_range(7));
      s_rb        = ($urandom_range(4) == 0) ? s_ra : 3'($urandom_range(7));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
